// File: rtl/control_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// control_pkg : opcodes, aluCtrl encodings and enums for multicycle_control
// Revision 1.0
// ---------------------------------------------------------------------------
package control_pkg;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDA = 6'b100000;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_NORA = 6'b100110;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_NOTA = 6'b000100;
  localparam logic [5:0] OP_BLEU = 6'b010000;
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_RORV = 6'b000010;

  localparam logic [4:0] ALU_DEFAULT = 5'b00000;
  localparam logic [4:0] ALU_NOT     = 5'b00100;
  localparam logic [4:0] ALU_ROL     = 5'b01000;
  localparam logic [4:0] ALU_ROR     = 5'b11000;
  localparam logic [4:0] ALU_NOR     = 5'b10000;

  typedef enum logic [1:0] {
    EXEC   = 2'd0,
    MEM    = 2'd1,
    BRANCH = 2'd2,
    HALT   = 2'd3
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_JUMP    = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_t;

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// control_decode : combinational opcode -> class, aluCtrl and static controls
// Revision 1.0
// ---------------------------------------------------------------------------
module control_decode
  import control_pkg::*;
(
  input  logic [5:0] opcode_i,
  output op_class_t  op_class_o,
  output logic [4:0] alu_ctrl_o,
  output logic       reg_write_o,
  output logic       alu_src_o,
  output logic       ja_o,
  output logic       jjr_o,
  output logic       link_o
);

  always_comb begin
    op_class_o  = CLS_ILLEGAL;
    alu_ctrl_o  = ALU_DEFAULT;
    reg_write_o = 1'b0;
    alu_src_o   = 1'b0;
    ja_o        = 1'b0;
    jjr_o       = 1'b0;
    link_o      = 1'b0;
    case (opcode_i)
      OP_ADDA: begin
        op_class_o  = CLS_ALU;
        reg_write_o = 1'b1;
      end
      OP_NORA: begin
        op_class_o  = CLS_ALU;
        reg_write_o = 1'b1;
        alu_ctrl_o  = ALU_NOR;
      end
      OP_NORI: begin
        op_class_o  = CLS_ALU;
        reg_write_o = 1'b1;
        alu_ctrl_o  = ALU_NOR;
        alu_src_o   = 1'b1;
      end
      OP_NOTA: begin
        op_class_o  = CLS_ALU;
        reg_write_o = 1'b1;
        alu_ctrl_o  = ALU_NOT;
        alu_src_o   = 1'b1;
      end
      OP_ROLV: begin
        op_class_o  = CLS_ALU;
        reg_write_o = 1'b1;
        alu_ctrl_o  = ALU_ROL;
      end
      OP_RORV: begin
        op_class_o  = CLS_ALU;
        reg_write_o = 1'b1;
        alu_ctrl_o  = ALU_ROR;
      end
      OP_JAL: begin
        op_class_o  = CLS_JUMP;
        reg_write_o = 1'b1;
        ja_o        = 1'b1;
        link_o      = 1'b1;
      end
      OP_JR: begin
        op_class_o  = CLS_JUMP;
        ja_o        = 1'b1;
        jjr_o       = 1'b1;
      end
      OP_LW:   op_class_o = CLS_LOAD;
      OP_SW:   op_class_o = CLS_STORE;
      OP_BLEU: op_class_o = CLS_BRANCH;
      default: op_class_o = CLS_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_control : phase FSM, memory wait counter and enable masking
// Revision 1.0
// ---------------------------------------------------------------------------
module multicycle_control
  import control_pkg::*;
#(
  parameter int MEM_WAIT        = 0,
  parameter int TRAP_ON_ILLEGAL = 0,
  parameter int WAIT_W          = $clog2(MEM_WAIT + 2)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic        stall,
  output logic        memWrite,
  output logic        regWriteEnable,
  output logic        aluSrc,
  output logic        jjr,
  output logic        ja,
  output logic        link,
  output logic        brancha,
  output logic        memtoReg,
  output logic [4:0]  aluCtrl,
  output logic        pcEnable,
  output logic        IRegEnable,
  output logic        IorD,
  output logic        regAEnable,
  output logic        illegalOp,
  output logic        halted
);

  ctrl_state_t       state_q, state_d;
  op_class_t         cls_q, cls_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  op_class_t  dec_class;
  logic [4:0] dec_alu;
  logic       dec_rw, dec_as, dec_ja, dec_jjr, dec_link;
  logic       unused_ins_bits;

  assign unused_ins_bits = ^ins[25:0];

  control_decode u_decode (
    .opcode_i    (ins[31:26]),
    .op_class_o  (dec_class),
    .alu_ctrl_o  (dec_alu),
    .reg_write_o (dec_rw),
    .alu_src_o   (dec_as),
    .ja_o        (dec_ja),
    .jjr_o       (dec_jjr),
    .link_o      (dec_link)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EXEC;
      cls_q   <= CLS_ALU;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cls_d          = cls_q;
    cnt_d          = cnt_q;
    memWrite       = 1'b0;
    regWriteEnable = 1'b0;
    aluSrc         = 1'b0;
    jjr            = 1'b0;
    ja             = 1'b0;
    link           = 1'b0;
    brancha        = 1'b0;
    memtoReg       = 1'b0;
    aluCtrl        = ALU_DEFAULT;
    pcEnable       = 1'b0;
    IRegEnable     = 1'b0;
    IorD           = 1'b0;
    regAEnable     = 1'b0;
    illegalOp      = 1'b0;
    halted         = 1'b0;

    // Reset zeroes every output combinationally, before the flops settle
    if (!reset) begin
      case (state_q)
        EXEC: begin
          cls_d   = dec_class;
          IorD    = 1'b1;
          aluCtrl = dec_alu;
          case (dec_class)
            CLS_ALU, CLS_JUMP: begin
              pcEnable       = 1'b1;
              IRegEnable     = 1'b1;
              regAEnable     = 1'b1;
              regWriteEnable = dec_rw;
              aluSrc         = dec_as;
              ja             = dec_ja;
              jjr            = dec_jjr;
              link           = dec_link;
            end
            CLS_LOAD, CLS_STORE: begin
              IRegEnable = 1'b1;
              regAEnable = 1'b1;
              aluSrc     = 1'b1;
              cnt_d      = WAIT_W'(MEM_WAIT);
              state_d    = MEM;
            end
            CLS_BRANCH: begin
              brancha = 1'b1;
              state_d = BRANCH;
            end
            default: begin
              illegalOp = 1'b1;
              if (TRAP_ON_ILLEGAL != 0) begin
                state_d = HALT;
              end else begin
                pcEnable = 1'b1;
              end
            end
          endcase
        end
        MEM: begin
          aluSrc = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - WAIT_W'(1);
          end else begin
            memWrite       = (cls_q == CLS_STORE);
            memtoReg       = (cls_q == CLS_LOAD);
            regWriteEnable = (cls_q == CLS_LOAD);
            pcEnable       = 1'b1;
            state_d        = EXEC;
          end
        end
        BRANCH: begin
          brancha  = 1'b1;
          aluSrc   = 1'b1;
          pcEnable = 1'b1;
          state_d  = EXEC;
        end
        default: begin
          halted = 1'b1;
        end
      endcase

      // A stalled final MEM cycle simply repeats, so the write issues once later
      if (stall) begin
        state_d        = state_q;
        cls_d          = cls_q;
        cnt_d          = cnt_q;
        pcEnable       = 1'b0;
        IRegEnable     = 1'b0;
        regAEnable     = 1'b0;
        regWriteEnable = 1'b0;
        memWrite       = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_control : scoreboard bench over three parameterisations
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  typedef struct {
    string       name;
    logic [18:0] v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ins;
  logic        stall;
  logic [1:0]  sel;
  wire  [18:0] o0, o3, o2;
  logic [18:0] obs;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // bits: mw rw as jjr ja link br m2r alu[4:0] pc ir iord ra ill halt
  multicycle_control #(.MEM_WAIT(0), .TRAP_ON_ILLEGAL(0)) dut0 (
    .clk(clk), .reset(reset), .ins(ins), .stall(stall),
    .memWrite(o0[18]), .regWriteEnable(o0[17]), .aluSrc(o0[16]), .jjr(o0[15]),
    .ja(o0[14]), .link(o0[13]), .brancha(o0[12]), .memtoReg(o0[11]),
    .aluCtrl(o0[10:6]), .pcEnable(o0[5]), .IRegEnable(o0[4]), .IorD(o0[3]),
    .regAEnable(o0[2]), .illegalOp(o0[1]), .halted(o0[0])
  );

  multicycle_control #(.MEM_WAIT(3), .TRAP_ON_ILLEGAL(1)) dut3 (
    .clk(clk), .reset(reset), .ins(ins), .stall(stall),
    .memWrite(o3[18]), .regWriteEnable(o3[17]), .aluSrc(o3[16]), .jjr(o3[15]),
    .ja(o3[14]), .link(o3[13]), .brancha(o3[12]), .memtoReg(o3[11]),
    .aluCtrl(o3[10:6]), .pcEnable(o3[5]), .IRegEnable(o3[4]), .IorD(o3[3]),
    .regAEnable(o3[2]), .illegalOp(o3[1]), .halted(o3[0])
  );

  multicycle_control #(.MEM_WAIT(2), .TRAP_ON_ILLEGAL(0)) dut2 (
    .clk(clk), .reset(reset), .ins(ins), .stall(stall),
    .memWrite(o2[18]), .regWriteEnable(o2[17]), .aluSrc(o2[16]), .jjr(o2[15]),
    .ja(o2[14]), .link(o2[13]), .brancha(o2[12]), .memtoReg(o2[11]),
    .aluCtrl(o2[10:6]), .pcEnable(o2[5]), .IRegEnable(o2[4]), .IorD(o2[3]),
    .regAEnable(o2[2]), .illegalOp(o2[1]), .halted(o2[0])
  );

  always_comb begin
    case (sel)
      2'd1:    obs = o3;
      2'd2:    obs = o2;
      default: obs = o0;
    endcase
  end

  function automatic logic [18:0] ev(input logic mw, rw, as_, jj, jaa, lk, br, m2r,
                                     input logic [4:0] alu,
                                     input logic pc, ir, iod, ra, ill, hlt);
    return {mw, rw, as_, jj, jaa, lk, br, m2r, alu, pc, ir, iod, ra, ill, hlt};
  endfunction

  function automatic logic [31:0] op(input logic [5:0] o);
    return {o, 26'h155_5555};
  endfunction

  // Single-cycle ALU/jump op in EXEC
  function automatic logic [18:0] ex1(input logic rw, as_, jj, jaa, lk, input logic [4:0] alu);
    return ev(1'b0, rw, as_, jj, jaa, lk, 1'b0, 1'b0, alu, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  localparam logic [18:0] ZERO     = 19'b0;
  localparam logic [18:0] MEM_ENT  = 19'b0_0_1_0_0_0_0_0_00000_0_1_1_1_0_0; // EXEC lw/sw
  localparam logic [18:0] MEM_WAIT = 19'b0_0_1_0_0_0_0_0_00000_0_0_0_0_0_0; // MEM waiting
  localparam logic [18:0] HALTV    = 19'b0_0_0_0_0_0_0_0_00000_0_0_0_0_0_1;

  task automatic step(input string nm, input logic [31:0] i, input logic st,
                      input logic rs, input logic [18:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    ins   = i;
    stall = st;
    reset = rs;
    x.name = nm;
    x.v    = e;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      if (obs !== x.v) begin
        errors++;
        $display("FAIL %s dut%0d got %b expected %b", x.name, sel, obs, x.v);
      end
    end
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    ins   = op(6'b100000);
    sel   = 2'd0;

    // MEM_WAIT=0, no trap
    step("reset", op(6'b100000), 1'b0, 1'b1, ZERO);
    step("adda", op(6'b100000), 1'b0, 1'b0, ex1(1, 0, 0, 0, 0, 5'b00000));
    step("nora", op(6'b100110), 1'b0, 1'b0, ex1(1, 0, 0, 0, 0, 5'b10000));
    step("nori", op(6'b001110), 1'b0, 1'b0, ex1(1, 1, 0, 0, 0, 5'b10000));
    step("nota", op(6'b000100), 1'b0, 1'b0, ex1(1, 1, 0, 0, 0, 5'b00100));
    step("rolv", op(6'b000000), 1'b0, 1'b0, ex1(1, 0, 0, 0, 0, 5'b01000));
    step("rorv", op(6'b000010), 1'b0, 1'b0, ex1(1, 0, 0, 0, 0, 5'b11000));
    step("jal",  op(6'b000011), 1'b0, 1'b0, ex1(1, 0, 0, 1, 1, 5'b00000));
    step("jr",   op(6'b001000), 1'b0, 1'b0, ex1(0, 0, 1, 1, 0, 5'b00000));
    step("bleu_c1", op(6'b010000), 1'b0, 1'b0,
         ev(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 1, 0, 0, 0));
    step("bleu_c2", op(6'b111111), 1'b0, 1'b0,
         ev(0, 0, 1, 0, 0, 0, 1, 0, 5'b00000, 1, 0, 0, 0, 0, 0));
    step("ill_nop", op(6'b111111), 1'b0, 1'b0,
         ev(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0, 1, 0, 1, 0));
    step("after_nop", op(6'b100000), 1'b0, 1'b0, ex1(1, 0, 0, 0, 0, 5'b00000));
    // sw, final MEM cycle stalled twice; bus shows lw meanwhile
    step("sw_exec", op(6'b101011), 1'b0, 1'b0, MEM_ENT);
    step("sw_stall1", op(6'b100011), 1'b1, 1'b0, MEM_WAIT);
    step("sw_stall2", op(6'b100011), 1'b1, 1'b0, MEM_WAIT);
    step("sw_write", op(6'b100011), 1'b0, 1'b0,
         ev(1, 0, 1, 0, 0, 0, 0, 0, 5'b00000, 1, 0, 0, 0, 0, 0));
    step("after_sw", op(6'b100110), 1'b0, 1'b0, ex1(1, 0, 0, 0, 0, 5'b10000));

    // MEM_WAIT=3, trap on illegal
    step("reset2", op(6'b100000), 1'b0, 1'b1, ZERO);
    sel = 2'd1;
    step("lw_c1", op(6'b100011), 1'b0, 1'b0, MEM_ENT);
    step("lw_c2", op(6'b101011), 1'b0, 1'b0, MEM_WAIT);
    step("lw_c3", op(6'b101011), 1'b0, 1'b0, MEM_WAIT);
    step("lw_c4", op(6'b101011), 1'b0, 1'b0, MEM_WAIT);
    step("lw_c5", op(6'b101011), 1'b0, 1'b0,
         ev(0, 1, 1, 0, 0, 0, 0, 1, 5'b00000, 1, 0, 0, 0, 0, 0));
    step("after_lw", op(6'b000100), 1'b0, 1'b0, ex1(1, 1, 0, 0, 0, 5'b00100));
    step("ill_trap", op(6'b111111), 1'b0, 1'b0,
         ev(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 1, 0, 1, 0));
    for (int k = 0; k < 11; k++) begin
      step("halted", op(6'b100000), 1'b0, 1'b0, HALTV);
    end
    step("halt_reset", op(6'b100000), 1'b0, 1'b1, ZERO);
    step("after_halt", op(6'b100000), 1'b0, 1'b0, ex1(1, 0, 0, 0, 0, 5'b00000));

    // MEM_WAIT=2, reset in the second MEM cycle of sw
    step("reset3", op(6'b100000), 1'b0, 1'b1, ZERO);
    sel = 2'd2;
    step("sw2_exec", op(6'b101011), 1'b0, 1'b0, MEM_ENT);
    step("sw2_mem1", op(6'b101011), 1'b0, 1'b0, MEM_WAIT);
    step("sw2_abort", op(6'b101011), 1'b0, 1'b1, ZERO);
    step("post_abort", op(6'b100000), 1'b0, 1'b0, ex1(1, 0, 0, 0, 0, 5'b00000));
    step("post_abort2", op(6'b001000), 1'b0, 1'b0, ex1(0, 0, 1, 1, 0, 5'b00000));

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
